// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI4 encodings and FSM state types for the SRAM responder.
//   RESP_*   : BRESP/RRESP codes
//   BURST_*  : AxBURST codes
//   SIZE_4B  : the only accepted AxSIZE (one full 32-bit word per beat)
//   w_state_e / r_state_e : write and read FSM states
//   resp_code(): folds the per-burst error flags into a response code
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Decode error wins over slave error.
    function automatic logic [1:0] resp_code(input logic decerr, input logic slverr);
        if (decerr) return RESP_DECERR;
        if (slverr) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/sram_word_array.sv
// -----------------------------------------------------------------------------
// sram_word_array
// WORDS x DATA_W memory, one byte-enabled write port and one registered read
// port. Contents are never initialised or reset. A read and write to the same
// word on the same edge returns the old contents.
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write word index
//   i_wstrb  in   byte enables
//   i_wdata  in   write data
//   i_re     in   read enable; o_rdata holds its value while i_re is low
//   i_raddr  in   read word index
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module sram_word_array #(
    parameter int WORDS  = 16384,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(WORDS),
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
// AXI4 responder in front of a byte-writable word memory. Independent read and
// write FSMs, one outstanding burst per direction, INCR bursts of 1..16 beats.
//   aclk, aresetn                      clock, asynchronous active-low reset
//   aw* / awready                      write address channel
//   w*  / wready                       write data channel
//   bid, bresp, bvalid / bready        write response channel
//   ar* / arready                      read address channel
//   rid, rdata, rresp, rlast, rvalid / rready   read data channel
// Errors: DECERR when the start address lies beyond the memory, SLVERR for a
// size other than 4 bytes, a non-INCR burst, or a WLAST that disagrees with the
// slave's own beat count. Erroneous bursts still run their full length.
// -----------------------------------------------------------------------------
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int MEM_WORDS  = 16384
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int IDX = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (IDX + 2)) != '0;
    endfunction

    function automatic logic bad_format(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_4B) || (burst != BURST_INCR);
    endfunction

    // ---------------- write side ----------------
    w_state_e              r_wstate;
    logic                  r_awready, r_wready, r_bvalid;
    logic [1:0]            r_bresp;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [LEN_WIDTH-1:0]  r_wlen, r_wbeat;
    logic                  r_w_decerr, r_w_slverr;

    logic w_w_hs, w_w_final, w_wlast_err, w_mem_we;

    assign w_w_hs      = wvalid & r_wready;
    assign w_w_final   = (r_wbeat == r_wlen);
    assign w_wlast_err = (wlast != w_w_final);
    // Once any error is known for this burst, memory is left untouched.
    assign w_mem_we    = w_w_hs & ~r_w_decerr & ~r_w_slverr & ~w_wlast_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_bid      <= '0;
            r_waddr    <= '0;
            r_wlen     <= '0;
            r_wbeat    <= '0;
            r_w_decerr <= 1'b0;
            r_w_slverr <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (awvalid) begin
                    r_bid      <= awid;
                    r_waddr    <= awaddr;
                    r_wlen     <= awlen;
                    r_wbeat    <= '0;
                    r_w_decerr <= out_of_range(awaddr);
                    r_w_slverr <= bad_format(awsize, awburst);
                    r_awready  <= 1'b0;
                    r_wready   <= 1'b1;
                    r_wstate   <= W_DATA;
                end
                W_DATA: if (wvalid) begin
                    r_waddr <= r_waddr + ADDR_STEP;
                    r_wbeat <= r_wbeat + LEN_WIDTH'(1);
                    if (w_wlast_err) r_w_slverr <= 1'b1;
                    // The slave's own beat count ends the burst, not WLAST.
                    if (w_w_final) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= resp_code(r_w_decerr, r_w_slverr | w_wlast_err);
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: if (bready) begin
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_wstate  <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read side ----------------
    r_state_e              r_rstate;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [1:0]            r_rresp;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [ADDR_WIDTH-1:0] r_raddr;   // address of the next beat to fetch
    logic [LEN_WIDTH-1:0]  r_rlen, r_rbeat;

    logic                  w_ar_hs, w_r_hs, w_mem_re;
    logic [IDX-1:0]        w_mem_raddr;
    logic [LEN_WIDTH-1:0]  w_rbeat_nxt;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_ar_hs     = arvalid & r_arready;
    assign w_r_hs      = r_rvalid & rready;
    // Fetch the next word on the same edge a non-last beat is accepted so
    // rvalid stays high without a bubble; a stalled beat holds the RAM output.
    assign w_mem_re    = w_ar_hs | (w_r_hs & ~r_rlast);
    assign w_mem_raddr = w_ar_hs ? araddr[IDX+1:2] : r_raddr[IDX+1:2];
    assign w_rbeat_nxt = r_rbeat + LEN_WIDTH'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (arvalid) begin
                    r_rid     <= arid;
                    r_rlen    <= arlen;
                    r_rbeat   <= '0;
                    r_raddr   <= araddr + ADDR_STEP;
                    r_rresp   <= resp_code(out_of_range(araddr), bad_format(arsize, arburst));
                    r_rvalid  <= 1'b1;
                    r_rlast   <= (arlen == '0);
                    r_arready <= 1'b0;
                    r_rstate  <= R_DATA;
                end
                R_DATA: if (rready) begin
                    if (r_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end else begin
                        r_raddr <= r_raddr + ADDR_STEP;
                        r_rbeat <= w_rbeat_nxt;
                        r_rlast <= (w_rbeat_nxt == r_rlen);
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    sram_word_array #(
        .WORDS  (MEM_WORDS),
        .DATA_W (DATA_WIDTH)
    ) u_mem (
        .clk     (aclk),
        .i_we    (w_mem_we),
        .i_waddr (r_waddr[IDX+1:2]),
        .i_wstrb (wstrb),
        .i_wdata (wdata),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_rdata (w_mem_rdata)
    );

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign bid     = r_bid;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rresp   = r_rresp;
    assign rid     = r_rid;
    // Error beats and idle cycles present zero data.
    assign rdata   = (r_rvalid && r_rresp == RESP_OKAY) ? w_mem_rdata : '0;

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

    localparam int MW = 16384;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [7:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;

    axi_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] mm [int];          // reference memory, word index -> contents
    int          vectors = 0;
    int          errors  = 0;
    bit          r_active = 1'b0;   // a read burst is in flight: rvalid must be high

    logic [31:0] rx_data [16];
    logic [1:0]  rx_resp [16];
    logic        rx_last [16];
    int          rx_n = 0;
    logic [1:0]  last_bresp = '0;
    logic [7:0]  last_bid = '0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Single compare process: every cycle a channel carries a valid response.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", 64'(rvalid), 64'd0);
                end else begin
                    rbeat_t act;
                    act = {rid, rdata, rresp, rlast};
                    check("r_beat", 64'(act), 64'(exp_r[0]));
                    if (rready) begin
                        if (rx_n < 16) begin
                            rx_data[rx_n] = rdata;
                            rx_resp[rx_n] = rresp;
                            rx_last[rx_n] = rlast;
                        end
                        rx_n++;
                        void'(exp_r.pop_front());
                    end
                end
            end else if (r_active && exp_r.size() != 0) begin
                check("r_bubble", 64'(rvalid), 64'd1);
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 64'(bvalid), 64'd0);
                end else begin
                    check("b_resp", 64'({bid, bresp}), 64'(exp_b[0]));
                    if (bready) begin
                        last_bresp = bresp;
                        last_bid   = bid;
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    // Wait for the ready of channel ch (0=AW,1=W,2=AR) while valid is held.
    task automatic hs_wait(input int ch, input string nm);
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge aclk);
            done = (ch == 0) ? awready : (ch == 1) ? wready : arready;
            @(posedge aclk);
            #1;
            n++;
            if (!done && n > 50) begin
                $display("FAIL %s_timeout: no ready after %0d cycles, expected ready", nm, n);
                $fatal(1, "handshake timeout");
            end
        end
    endtask

    function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input bit wlast_bad);
        if (addr >= 32'(MW * 4)) return 2'b11;
        if (size != 3'd2 || burst != 2'b01 || wlast_bad) return 2'b10;
        return 2'b00;
    endfunction

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int wlast_at, input int bdelay);
        logic [1:0] er;
        int n;
        er = model_resp(addr, size, burst, wlast_at != len);
        if (er == 2'b00) begin
            for (int i = 0; i <= len; i++) begin
                logic [31:0] a;
                logic [31:0] w;
                int idx;
                a   = addr + 32'(4 * i);
                idx = int'((a / 32'd4) % 32'(MW));
                w   = mm.exists(idx) ? mm[idx] : 32'h0;
                for (int b = 0; b < 4; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
                mm[idx] = w;
            end
        end
        exp_b.push_back({id, er});
        bready  = (bdelay == 0);
        awid    = id;
        awaddr  = addr;
        awlen   = 4'(len);
        awsize  = size;
        awburst = burst;
        awvalid = 1'b1;
        hs_wait(0, "aw");
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (i == wlast_at);
            wvalid = 1'b1;
            hs_wait(1, "w");
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (bdelay > 0) begin
            repeat (bdelay) @(posedge aclk);
            #1;
            bready = 1'b1;
        end
        n = 0;
        while (exp_b.size() != 0 && n <= 50) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (n > 50) check("b_timeout", 64'(exp_b.size()), 64'd0);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall, output int cycles);
        logic [1:0] er;
        int n;
        er = model_resp(addr, size, burst, 1'b0);
        for (int i = 0; i <= len; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            int idx;
            a   = addr + 32'(4 * i);
            idx = int'((a / 32'd4) % 32'(MW));
            d   = (er != 2'b00) ? 32'h0 : (mm.exists(idx) ? mm[idx] : 32'h0);
            exp_r.push_back({id, d, er, 1'(i == len)});
        end
        rx_n    = 0;
        rready  = (stall == 0);
        arid    = id;
        araddr  = addr;
        arlen   = 4'(len);
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        hs_wait(2, "ar");
        arvalid  = 1'b0;
        r_active = 1'b1;
        if (stall > 0) begin
            repeat (stall) @(posedge aclk);
            #1;
            rready = 1'b1;
        end
        n = 0;
        while (exp_r.size() != 0 && n <= 100) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (n > 100) check("r_timeout", 64'(exp_r.size()), 64'd0);
        r_active = 1'b0;
        cycles   = n;
    endtask

    initial begin
        int cyc;
        int n;

        // Reset
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("rst_awready", 64'(awready), 64'd1);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_rdata",   64'(rdata),   64'd0);
        check("rst_rlast",   64'(rlast),   64'd0);
        check("rst_bresp",   64'(bresp),   64'd0);
        @(posedge aclk);
        #1;

        // 1) single write then single read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(8'h12, 32'h100, 0, 3'd2, 2'b01, 0, 0);
        check("t1_bresp", 64'(last_bresp), 64'd0);
        check("t1_bid",   64'(last_bid),   64'h12);
        do_read(8'h34, 32'h100, 0, 3'd2, 2'b01, 0, cyc);
        check("t1_rdata", 64'(rx_data[0]), 64'hDEADBEEF);
        check("t1_rlast", 64'(rx_last[0]), 64'd1);

        // 2) INCR burst of 4, read back at full rate
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(8'h21, 32'h200, 3, 3'd2, 2'b01, 3, 0);
        check("t2_bresp", 64'(last_bresp), 64'd0);
        do_read(8'h22, 32'h200, 3, 3'd2, 2'b01, 0, cyc);
        check("t2_cycles", 64'(cyc), 64'd4);
        check("t2_beat0", 64'(rx_data[0]), 64'h11);
        check("t2_beat3", 64'(rx_data[3]), 64'h44);
        check("t2_last3", 64'(rx_last[3]), 64'd1);
        check("t2_last2", 64'(rx_last[2]), 64'd0);

        // 3) partial strobes
        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write(8'h30, 32'h0, 0, 3'd2, 2'b01, 0, 0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(8'h31, 32'h0, 0, 3'd2, 2'b01, 0, 0);
        do_read(8'h32, 32'h0, 0, 3'd2, 2'b01, 0, cyc);
        check("t3_strb", 64'(rx_data[0]), 64'h00BB00DD);

        // 4) decode errors
        do_read(8'h44, 32'h0001_0000, 1, 3'd2, 2'b01, 0, cyc);
        check("t4_rresp0", 64'(rx_resp[0]), 64'd3);
        check("t4_rresp1", 64'(rx_resp[1]), 64'd3);
        check("t4_rdata1", 64'(rx_data[1]), 64'd0);
        check("t4_nbeats", 64'(rx_n), 64'd2);
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(8'h45, 32'h0001_0100, 0, 3'd2, 2'b01, 0, 0);
        check("t4_bresp", 64'(last_bresp), 64'd3);
        do_read(8'h46, 32'h100, 0, 3'd2, 2'b01, 0, cyc);
        check("t4_unchanged", 64'(rx_data[0]), 64'hDEADBEEF);

        // 5) slave errors
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        do_write(8'h50, 32'h300, 0, 3'd2, 2'b01, 0, 0);
        wd[0] = 32'h0;
        do_write(8'h51, 32'h300, 0, 3'd2, 2'b10, 0, 0);
        check("t5_wrap_bresp", 64'(last_bresp), 64'd2);
        do_write(8'h52, 32'h300, 0, 3'd1, 2'b01, 0, 0);
        check("t5_size_bresp", 64'(last_bresp), 64'd2);
        do_read(8'h53, 32'h300, 0, 3'd2, 2'b01, 0, cyc);
        check("t5_no_write", 64'(rx_data[0]), 64'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h77; ws[i] = 4'hF; end
        do_write(8'h54, 32'h400, 3, 3'd2, 2'b01, 1, 0);
        check("t5_wlast_bresp", 64'(last_bresp), 64'd2);
        do_read(8'h55, 32'h300, 0, 3'd1, 2'b01, 0, cyc);
        check("t5_rsize_resp", 64'(rx_resp[0]), 64'd2);
        check("t5_rsize_data", 64'(rx_data[0]), 64'd0);
        do_read(8'h56, 32'h0001_0000, 0, 3'd2, 2'b10, 0, cyc);
        check("t5_dec_prec", 64'(rx_resp[0]), 64'd3);

        // 6) back-pressure on B and R, then reset mid-read
        wd[0] = 32'h5555AAAA; ws[0] = 4'hF;
        do_write(8'h66, 32'h500, 0, 3'd2, 2'b01, 0, 5);
        check("t6_bid", 64'(last_bid), 64'h66);
        do_read(8'h67, 32'h200, 1, 3'd2, 2'b01, 3, cyc);
        check("t6_stall_beat1", 64'(rx_data[1]), 64'h22);

        exp_r.push_back({8'h68, 32'h11, 2'b00, 1'b0});
        exp_r.push_back({8'h68, 32'h22, 2'b00, 1'b0});
        exp_r.push_back({8'h68, 32'h33, 2'b00, 1'b0});
        exp_r.push_back({8'h68, 32'h44, 2'b00, 1'b1});
        rready = 1'b1; arid = 8'h68; araddr = 32'h200; arlen = 4'd3;
        arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        hs_wait(2, "ar");
        arvalid  = 1'b0;
        r_active = 1'b1;
        n = 0;
        while (exp_r.size() > 3 && n < 20) begin @(negedge aclk); n++; end
        @(posedge aclk);
        #2;
        r_active = 1'b0;
        exp_r.delete();
        check("t6_beat2_shown", 64'(rvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        check("t6_rst_rvalid", 64'(rvalid), 64'd0);
        check("t6_rst_rlast",  64'(rlast),  64'd0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("t6_rel_arready", 64'(arready), 64'd1);
        check("t6_rel_rvalid",  64'(rvalid),  64'd0);
        @(posedge aclk);
        #1;
        do_read(8'h69, 32'h200, 0, 3'd2, 2'b01, 0, cyc);
        check("t6_retained", 64'(rx_data[0]), 64'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
